spi_byte_engine: RTL

SPI_BYTE_ENGINE -- requirements
Module: spi_byte_engine

---
 rtl/spi_byte_engine.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_byte_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_engine
// Description : Single-byte SPI master, mode 0 (spi_clk idles low), MSB first.
//               One execute pulse moves one byte out on mosi while the byte on
//               miso is shifted in. The spi_clk half-period is chosen per
//               transfer from SLOW_DIV or FAST_DIV by the fast input.
//
// Parameters  : SLOW_DIV  spi_clk half-period in clk cycles when fast=0 (>=1)
//               FAST_DIV  spi_clk half-period in clk cycles when fast=1 (>=1)
//
// Ports       : clk       master clock, rising edge
//               rst       synchronous active-high reset
//               execute   start a transfer (sampled only while idle)
//               fast      divider select, captured with execute
//               out_word  byte to transmit, captured with execute
//               miso      serial data from the card
//               spi_clk   serial clock
//               mosi      serial data to the card (high when idle)
//               in_word   last fully received byte
//               finished  one-cycle completion pulse (busy already low)
//               busy      transfer in progress
//
// Options     : SPI_BYTE_ENGINE_LOOPBACK_EN  when defined, the receive path
//               samples the engine's own mosi instead of the miso port.
//
// Revision    : 1.0  initial release
// ============================================================================
module spi_byte_engine #(
    parameter int SLOW_DIV = 64,
    parameter int FAST_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       execute,
    input  logic       fast,
    input  logic [7:0] out_word,
    input  logic       miso,
    output logic       spi_clk,
    output logic       mosi,
    output logic [7:0] in_word,
    output logic       finished,
    output logic       busy
);

    localparam int c_MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int c_CW      = $clog2(c_MAX_DIV) + 1;

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_SHIFT_LOW  = 2'd1;
    localparam logic [1:0] c_SHIFT_HIGH = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] r_half;
    logic [2:0]      r_bit;
    logic [7:0]      r_tx;
    logic [7:0]      r_rx;
    logic [7:0]      r_in_word;
    logic            r_finished;

    logic            w_tick;
    logic            w_last_bit;
    logic            w_mosi;
    logic            w_rx_bit;

    // Last clk cycle of the current spi_clk half-period.
    assign w_tick     = (r_cnt == (r_half - c_CW'(1)));
    assign w_last_bit = (r_bit == 3'd7);
    assign w_mosi     = (r_state == c_IDLE) ? 1'b1 : r_tx[7];

`ifdef SPI_BYTE_ENGINE_LOOPBACK_EN
    assign w_rx_bit = w_mosi;
`else
    assign w_rx_bit = miso;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (execute) begin
                    w_state_nxt = c_SHIFT_LOW;
                end
            end
            c_SHIFT_LOW: begin
                if (w_tick) begin
                    w_state_nxt = c_SHIFT_HIGH;
                end
            end
            c_SHIFT_HIGH: begin
                if (w_tick) begin
                    w_state_nxt = w_last_bit ? c_IDLE : c_SHIFT_LOW;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_half     <= '0;
            r_bit      <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_in_word  <= '0;
            r_finished <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_finished <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (execute) begin
                        r_tx   <= out_word;
                        r_half <= fast ? c_CW'(FAST_DIV) : c_CW'(SLOW_DIV);
                        r_bit  <= '0;
                        r_cnt  <= '0;
                    end
                end
                c_SHIFT_LOW: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        // Sample on the cycle that ends with spi_clk rising.
                        r_rx  <= {r_rx[6:0], w_rx_bit};
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_SHIFT_HIGH: begin
                    if (w_tick) begin
                        r_cnt <= '0;
                        if (!w_last_bit) begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= {r_tx[6:0], 1'b0};
                        end else begin
                            r_in_word  <= r_rx;
                            r_finished <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign spi_clk  = (r_state == c_SHIFT_HIGH);
    assign mosi     = w_mosi;
    assign busy     = (r_state != c_IDLE);
    assign finished = r_finished;
    assign in_word  = r_in_word;

endmodule
`default_nettype wire
